// File: rtl/cpu_param_pkg.sv
// Shared constants for the parametrised multicycle CPU: opcodes, FSM states, IR field positions.
package cpu_param_pkg;

  localparam int unsigned IR_W    = 16;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned RIDX_W  = 4;

  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS_HI  = 7;
  localparam int unsigned RS_LO  = 4;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_NOPD = 4'hD;
  localparam logic [3:0] OP_NOPE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH_HI = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM      = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  // Ops 0..7 (ALU class) update the Z/C flags.
  function automatic logic sets_flags(logic [3:0] op);
    return op <= OP_SHR;
  endfunction

endpackage

// File: rtl/cpu_multicycle_param_if.sv
// Status bundle exported by the core so a monitor can trace execution.
interface cpu_multicycle_param_if
  import cpu_param_pkg::*;
#(
  parameter int unsigned AW = 8
) ();
  logic [AW-1:0]      pc;
  logic [IR_W-1:0]    ir;
  logic               flag_c;
  logic               flag_z;
  logic               halted;
  logic [STATE_W-1:0] state;

  modport master (output pc, ir, flag_c, flag_z, halted, state);
  modport slave  (input  pc, ir, flag_c, flag_z, halted, state);
endinterface

// File: rtl/cpu_regfile.sv
// NREG x WIDTH register file: two async read ports, one sync write port, out-of-range indices guarded.
module cpu_regfile
  import cpu_param_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 16
) (
  input  logic              clk,
  input  logic [RIDX_W-1:0] raddr_a,
  input  logic [RIDX_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              wen,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata
);
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [WIDTH-1:0] regs [NREG];

  function automatic logic in_range(logic [RIDX_W-1:0] idx);
    return 32'(idx) < NREG;
  endfunction

  // Asynchronous reads; unimplemented registers read as zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (in_range(raddr_a)) rdata_a = regs[raddr_a[IW-1:0]];
    if (in_range(raddr_b)) rdata_b = regs[raddr_b[IW-1:0]];
  end

  // Synchronous write; writes to unimplemented registers are dropped.
  always_ff @(posedge clk) begin
    if (wen && in_range(waddr)) regs[waddr[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cpu_multicycle_param.sv
// Multicycle fetch/decode/execute core with byte-addressed unified memory and C/Z flags.
module cpu_multicycle_param
  import cpu_param_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NREG      = 16,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                          CK,
  input  logic                          RST_N,
  cpu_multicycle_param_if.master        st
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  state_t           state;
  logic [AW-1:0]    pc;
  logic [IR_W-1:0]  ir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flag_c;
  logic             flag_z;
  logic             halted;

  logic [7:0]       mem [MEM_DEPTH];

  logic [3:0]        op;
  logic [RIDX_W-1:0] rd_idx;
  logic [RIDX_W-1:0] rs_idx;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              rf_wen;
  logic [WIDTH-1:0]  rf_wdata;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_rdata;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c;

  assign op        = ir[OP_HI:OP_LO];
  assign rd_idx    = ir[RD_HI:RD_LO];
  assign rs_idx    = ir[RS_HI:RS_LO];
  assign mem_addr  = AW'(b);
  assign mem_rdata = mem[mem_addr];

  // Writeback happens on the EXEC edge for ALU/LDI and on the MEM edge for LD; reset suppresses it.
  assign rf_wen   = RST_N && (((state == ST_EXEC) && (op <= OP_LDI)) ||
                              ((state == ST_MEM) && (op == OP_LD)));
  assign rf_wdata = (state == ST_MEM) ? WIDTH'(mem_rdata) : alu_res;

  cpu_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk     (CK),
    .raddr_a (rd_idx),
    .raddr_b (rs_idx),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .wen     (rf_wen),
    .waddr   (rd_idx),
    .wdata   (rf_wdata)
  );

  // Combinational ALU on the latched operands; C defaults to its current value.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = flag_c;
    case (op)
      OP_ADD: begin
        sum     = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_c   = a < b;
      end
      OP_AND: begin alu_res = a & b; alu_c = 1'b0; end
      OP_OR:  begin alu_res = a | b; alu_c = 1'b0; end
      OP_XOR: begin alu_res = a ^ b; alu_c = 1'b0; end
      OP_NOT: begin alu_res = ~b;    alu_c = 1'b0; end
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_LDI: alu_res = WIDTH'(ir[IMM_HI:IMM_LO]);
      default: ;
    endcase
  end

  // Store port: only in MEM for ST, blocked while reset is asserted.
  always_ff @(posedge CK) begin
    if (RST_N && (state == ST_MEM) && (op == OP_ST)) mem[mem_addr] <= a[7:0];
  end

  // Sequencer: fetch two bytes, latch operands, execute, optional memory phase.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state  <= ST_FETCH_HI;
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_FETCH_HI: begin
          ir[15:8] <= mem[pc];
          state    <= ST_FETCH_LO;
        end
        ST_FETCH_LO: begin
          ir[7:0] <= mem[pc + AW'(1)];
          state   <= ST_DECODE;
        end
        ST_DECODE: begin
          a     <= rdata_a;
          b     <= rdata_b;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (sets_flags(op)) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          case (op)
            OP_LD, OP_ST: state <= ST_MEM;
            OP_HALT: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            OP_JZ: begin
              pc    <= (a == '0) ? AW'(b) : pc + AW'(2);
              state <= ST_FETCH_HI;
            end
            OP_JMP: begin
              pc    <= AW'(b);
              state <= ST_FETCH_HI;
            end
            OP_NOPD, OP_NOPE: begin
              pc    <= pc + AW'(2);
              state <= ST_FETCH_HI;
            end
            default: begin
              pc    <= pc + AW'(2);
              state <= ST_FETCH_HI;
            end
          endcase
        end
        ST_MEM: begin
          pc    <= pc + AW'(2);
          state <= ST_FETCH_HI;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH_HI;
      endcase
    end
  end

  assign st.pc     = pc;
  assign st.ir     = ir;
  assign st.flag_c = flag_c;
  assign st.flag_z = flag_z;
  assign st.halted = halted;
  assign st.state  = state;

endmodule

// File: tb/tb_cpu_multicycle_param.sv
// Bench for cpu_multicycle_param: ALU vector table, hand sequences, random programs vs a reference model.
module tb_cpu_multicycle_param;
  import cpu_param_pkg::*;

  logic CK = 1'b0;
  logic rst16 = 1'b0;
  logic rst8  = 1'b0;

  always #5 CK = ~CK;

  cpu_multicycle_param_if #(.AW(8)) st16 ();
  cpu_multicycle_param_if #(.AW(8)) st8 ();

  cpu_multicycle_param #(.WIDTH(16), .NREG(16), .MEM_DEPTH(256)) dut16 (
    .CK(CK), .RST_N(rst16), .st(st16.master));
  cpu_multicycle_param #(.WIDTH(8), .NREG(4), .MEM_DEPTH(256)) dut8 (
    .CK(CK), .RST_N(rst8), .st(st8.master));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  // Hold dut16 in reset for one edge and blank its memory and registers.
  task automatic reset16();
    rst16 = 1'b0;
    tick(1);
    for (int i = 0; i < 256; i++) dut16.mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) dut16.u_rf.regs[i] = 16'h0000;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [7:0]  lo;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
    string       name;
  } vec_t;

  function automatic vec_t mk(logic [3:0] op, logic [3:0] rd, logic [7:0] lo, logic [15:0] a,
                              logic [15:0] b, logic [15:0] res, logic c, logic z, string name);
    vec_t v;
    v.op = op; v.rd = rd; v.lo = lo; v.a = a; v.b = b;
    v.res = res; v.c = c; v.z = z; v.name = name;
    return v;
  endfunction

  // Reference model state (16-bit build).
  logic [15:0] m_r   [16];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_pc;
  logic        m_c, m_z, m_halt;

  // Executes one instruction from the model memory; returns the cycles it costs.
  task automatic m_step(output int cyc);
    logic [7:0]  hi, lo, npc;
    int unsigned op, rd, rs, x, y, res;
    npc = m_pc + 8'd1;
    hi  = m_mem[m_pc];
    lo  = m_mem[npc];
    op  = int'(hi) >> 4;
    rd  = int'(hi) & 15;
    rs  = int'(lo) >> 4;
    x   = int'(m_r[rd]);
    y   = int'(m_r[rs]);
    res = 0;
    cyc = 4;
    if (op <= 7) begin
      case (op)
        0: begin res = x + y; m_c = ((res >> 16) & 1) != 0; res = res & 32'hFFFF; end
        1: begin m_c = x < y; res = (x - y) & 32'hFFFF; end
        2: begin res = x & y; m_c = 1'b0; end
        3: begin res = x | y; m_c = 1'b0; end
        4: begin res = x ^ y; m_c = 1'b0; end
        5: begin res = (~y) & 32'hFFFF; m_c = 1'b0; end
        6: begin m_c = ((x >> 15) & 1) != 0; res = (x << 1) & 32'hFFFF; end
        default: begin m_c = (x & 1) != 0; res = x >> 1; end
      endcase
      m_r[rd] = 16'(res);
      m_z     = (res == 0);
      m_pc    = m_pc + 8'd2;
    end else begin
      case (op)
        8:  begin m_r[rd] = 16'(lo); m_pc = m_pc + 8'd2; end
        9:  begin m_r[rd] = 16'(m_mem[y & 255]); m_pc = m_pc + 8'd2; cyc = 5; end
        10: begin m_mem[y & 255] = 8'(x & 255); m_pc = m_pc + 8'd2; cyc = 5; end
        11: m_pc = (x == 0) ? 8'(y & 255) : m_pc + 8'd2;
        12: m_pc = 8'(y & 255);
        15: m_halt = 1'b1;
        default: m_pc = m_pc + 8'd2;
      endcase
    end
  endtask

  vec_t vt[14];

  initial begin
    // ALU / LDI single-instruction vectors at address 0 on the 16-bit core.
    vt[0]  = mk(4'h0, 4'h1, 8'h20, 16'h0006, 16'h0003, 16'h0009, 1'b0, 1'b0, "add");
    vt[1]  = mk(4'h1, 4'h1, 8'h20, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, "sub_borrow");
    vt[2]  = mk(4'h0, 4'h1, 8'h20, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, "add_carry");
    vt[3]  = mk(4'h2, 4'h1, 8'h20, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, "and");
    vt[4]  = mk(4'h3, 4'h1, 8'h20, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, "or");
    vt[5]  = mk(4'h4, 4'h1, 8'h10, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, "xor_self");
    vt[6]  = mk(4'h5, 4'h1, 8'h20, 16'h1234, 16'h00FF, 16'hFF00, 1'b0, 1'b0, "not");
    vt[7]  = mk(4'h6, 4'h1, 8'h20, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0, "shl");
    vt[8]  = mk(4'h7, 4'h1, 8'h20, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, "shr_out");
    vt[9]  = mk(4'h1, 4'h1, 8'h10, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b1, "sub_self");
    vt[10] = mk(4'h8, 4'h1, 8'hA5, 16'hFFFF, 16'h0000, 16'h00A5, 1'b0, 1'b0, "ldi");
    vt[11] = mk(4'h1, 4'h3, 8'h40, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, "sub");
    vt[12] = mk(4'h7, 4'h1, 8'h20, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0, "shr");
    vt[13] = mk(4'h0, 4'h1, 8'h20, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, "add_wrap");

    // Reset state.
    reset16();
    chk("rst_pc", st16.pc, 8'h00);
    chk("rst_ir", st16.ir, 16'h0000);
    chk("rst_state", st16.state, 3'd0);
    chk("rst_halted", st16.halted, 1'b0);
    chk("rst_flags", {st16.flag_c, st16.flag_z}, 2'b00);

    foreach (vt[k]) begin
      reset16();
      dut16.u_rf.regs[vt[k].lo[7:4]] = vt[k].b;
      dut16.u_rf.regs[vt[k].rd]      = vt[k].a;
      dut16.mem[0] = {vt[k].op, vt[k].rd};
      dut16.mem[1] = vt[k].lo;
      rst16 = 1'b1;
      tick(4);
      chk({vt[k].name, "_res"}, dut16.u_rf.regs[vt[k].rd], vt[k].res);
      chk({vt[k].name, "_c"}, st16.flag_c, vt[k].c);
      chk({vt[k].name, "_z"}, st16.flag_z, vt[k].z);
      chk({vt[k].name, "_pc"}, st16.pc, 8'h02);
      chk({vt[k].name, "_state"}, st16.state, 3'd0);
    end

    // SUB with borrow, then XOR self clears the value and C.
    reset16();
    dut16.u_rf.regs[2] = 16'h0001;
    dut16.u_rf.regs[3] = 16'h0002;
    dut16.mem[0] = 8'h12; dut16.mem[1] = 8'h30;
    dut16.mem[2] = 8'h42; dut16.mem[3] = 8'h20;
    rst16 = 1'b1;
    tick(4);
    chk("seq_sub_r2", dut16.u_rf.regs[2], 16'hFFFF);
    chk("seq_sub_c", st16.flag_c, 1'b1);
    tick(4);
    chk("seq_xor_r2", dut16.u_rf.regs[2], 16'h0000);
    chk("seq_xor_cz", {st16.flag_c, st16.flag_z}, 2'b01);
    chk("seq_xor_pc", st16.pc, 8'h04);

    // LDI/ST/LD/HALT timing.
    reset16();
    dut16.mem[0] = 8'h84; dut16.mem[1] = 8'h5A;
    dut16.mem[2] = 8'h85; dut16.mem[3] = 8'h80;
    dut16.mem[4] = 8'hA4; dut16.mem[5] = 8'h50;
    dut16.mem[6] = 8'h96; dut16.mem[7] = 8'h50;
    dut16.mem[8] = 8'hF0; dut16.mem[9] = 8'h00;
    rst16 = 1'b1;
    tick(8);
    chk("ldi_r4", dut16.u_rf.regs[4], 16'h005A);
    chk("ldi_r5", dut16.u_rf.regs[5], 16'h0080);
    tick(4);
    chk("st_in_mem_state", st16.state, 3'd4);
    chk("st_pc_hold", st16.pc, 8'h04);
    tick(1);
    chk("st_done_state", st16.state, 3'd0);
    chk("st_pc", st16.pc, 8'h06);
    chk("st_mem80", dut16.mem[8'h80], 8'h5A);
    tick(4);
    chk("ld_not_yet", dut16.u_rf.regs[6], 16'h0000);
    tick(1);
    chk("ld_r6", dut16.u_rf.regs[6], 16'h005A);
    chk("ld_pc", st16.pc, 8'h08);
    tick(3);
    chk("halt_not_yet", st16.halted, 1'b0);
    tick(1);
    chk("halt_halted", st16.halted, 1'b1);
    chk("halt_state", st16.state, 3'd5);
    tick(20);
    chk("halt_pc_frozen", st16.pc, 8'h08);
    chk("halt_still", {st16.halted, st16.state}, {1'b1, 3'd5});

    // JZ taken / not taken.
    for (int t = 0; t < 2; t++) begin
      reset16();
      dut16.u_rf.regs[7] = 16'(t);
      dut16.u_rf.regs[8] = 16'h0010;
      dut16.mem[0] = 8'hB7; dut16.mem[1] = 8'h80;
      rst16 = 1'b1;
      tick(4);
      chk($sformatf("jz_%0d_pc", t), st16.pc, (t == 0) ? 8'h10 : 8'h02);
    end

    // JMP to 0xFE, then fetch rolls over to 0x00.
    reset16();
    dut16.u_rf.regs[9] = 16'h00FE;
    dut16.mem[0] = 8'hC0; dut16.mem[1] = 8'h90;
    dut16.mem[8'hFE] = 8'h8A; dut16.mem[8'hFF] = 8'h3C;
    rst16 = 1'b1;
    tick(4);
    chk("jmp_fe_pc", st16.pc, 8'hFE);
    tick(2);
    chk("jmp_fe_ir", st16.ir, 16'h8A3C);
    tick(2);
    chk("jmp_fe_r10", dut16.u_rf.regs[10], 16'h003C);
    chk("jmp_fe_wrap_pc", st16.pc, 8'h00);

    // JMP to 0xFF: low byte fetch wraps to mem[0].
    reset16();
    dut16.u_rf.regs[9] = 16'h00FF;
    dut16.mem[0] = 8'hC0; dut16.mem[1] = 8'h90;
    dut16.mem[8'hFF] = 8'h8B;
    rst16 = 1'b1;
    tick(6);
    chk("jmp_ff_ir", st16.ir, 16'h8BC0);
    tick(2);
    chk("jmp_ff_r11", dut16.u_rf.regs[11], 16'h00C0);
    chk("jmp_ff_pc", st16.pc, 8'h01);

    // Reset asserted during EXEC of an ADD leaves no trace.
    reset16();
    dut16.u_rf.regs[0] = 16'h0006;
    dut16.u_rf.regs[1] = 16'h0003;
    dut16.mem[0] = 8'h00; dut16.mem[1] = 8'h10;
    rst16 = 1'b1;
    tick(3);
    chk("rstx_exec_state", st16.state, 3'd3);
    rst16 = 1'b0;
    tick(1);
    chk("rstx_r0", dut16.u_rf.regs[0], 16'h0006);
    chk("rstx_pc", st16.pc, 8'h00);
    chk("rstx_state", st16.state, 3'd0);
    chk("rstx_ir", st16.ir, 16'h0000);

    // Narrow 8-bit build with 4 registers.
    rst8 = 1'b0;
    tick(1);
    for (int i = 0; i < 256; i++) dut8.mem[i] = 8'h00;
    dut8.u_rf.regs[0] = 8'hFF;
    dut8.u_rf.regs[1] = 8'h01;
    dut8.u_rf.regs[2] = 8'h01;
    dut8.u_rf.regs[3] = 8'h21;
    dut8.mem[0] = 8'h00; dut8.mem[1] = 8'h10;
    dut8.mem[2] = 8'h72; dut8.mem[3] = 8'h00;
    dut8.mem[4] = 8'h85; dut8.mem[5] = 8'h77;
    dut8.mem[6] = 8'h03; dut8.mem[7] = 8'h50;
    rst8 = 1'b1;
    tick(4);
    chk("w8_add_r0", dut8.u_rf.regs[0], 8'h00);
    chk("w8_add_cz", {st8.flag_c, st8.flag_z}, 2'b11);
    tick(4);
    chk("w8_shr_r2", dut8.u_rf.regs[2], 8'h00);
    chk("w8_shr_cz", {st8.flag_c, st8.flag_z}, 2'b11);
    tick(8);
    chk("w8_oor_r3", dut8.u_rf.regs[3], 8'h21);
    chk("w8_oor_cz", {st8.flag_c, st8.flag_z}, 2'b00);
    chk("w8_pc", st8.pc, 8'h08);

    // Random programs: whole memory and register file random, compare with the model.
    for (int t = 0; t < 20; t++) begin
      int total;
      int cyc;
      int bad_mem;
      reset16();
      for (int i = 0; i < 256; i++) begin
        m_mem[i] = 8'($urandom);
        dut16.mem[i] = m_mem[i];
      end
      for (int i = 0; i < 16; i++) begin
        m_r[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        dut16.u_rf.regs[i] = m_r[i];
      end
      m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
      total = 0;
      for (int k = 0; k < 25 && !m_halt; k++) begin
        m_step(cyc);
        total += cyc;
      end
      rst16 = 1'b1;
      tick(total);
      for (int i = 0; i < 16; i++)
        chk($sformatf("rnd%0d_r%0d", t, i), dut16.u_rf.regs[i], m_r[i]);
      chk($sformatf("rnd%0d_pc", t), st16.pc, m_pc);
      chk($sformatf("rnd%0d_c", t), st16.flag_c, m_c);
      chk($sformatf("rnd%0d_z", t), st16.flag_z, m_z);
      chk($sformatf("rnd%0d_halted", t), st16.halted, m_halt);
      chk($sformatf("rnd%0d_state", t), st16.state, m_halt ? 3'd5 : 3'd0);
      bad_mem = 0;
      for (int i = 0; i < 256; i++) if (dut16.mem[i] !== m_mem[i]) bad_mem++;
      chk($sformatf("rnd%0d_mem_diffs", t), 64'(bad_mem), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
